// File: rtl/interp_out_serializer.sv
// Output end of the 4x interpolator: normalizes and saturates one (A, B, C) triple
// and serializes it with its centre sample as four beats on a valid/ready stream.
module interp_out_serializer #(
    parameter int IN_W       = 40,
    parameter int OUT_W      = 32,
    parameter int NORM_SHIFT = 6,
    parameter int ROUND_EN   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] in_center,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic [IN_W-1:0]  in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_phase,
    output logic             out_last,
    output logic [15:0]      sat_count
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    localparam logic signed [IN_W:0] RND = (ROUND_EN != 0) ?
        {{(IN_W+1-NORM_SHIFT){1'b0}}, 1'b1, {(NORM_SHIFT-1){1'b0}}} : {(IN_W+1){1'b0}};
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Returns {saturated flag, normalized OUT_W-bit value}; the add is one bit wider than the input.
    function automatic logic [OUT_W:0] norm_sat(input logic [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] shifted;
        begin
            ext     = {x[IN_W-1], x};
            shifted = (ext + RND) >>> NORM_SHIFT;
            if (shifted > SAT_MAX) begin
                norm_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
            end else if (shifted < SAT_MIN) begin
                norm_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                norm_sat = {1'b0, shifted[OUT_W-1:0]};
            end
        end
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [1:0]         phase_r;
    logic [OUT_W-1:0]   a_r;
    logic [OUT_W-1:0]   b_r;
    logic [OUT_W-1:0]   c_r;
    logic [OUT_W-1:0]   out_data_r;
    logic               out_last_r;
    logic [15:0]        sat_count_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               beat_s;
    logic [OUT_W:0]     na_s;
    logic [OUT_W:0]     nb_s;
    logic [OUT_W:0]     nc_s;
    logic [1:0]         sat_inc_s;
    logic [16:0]        sat_sum_s;
    logic [15:0]        sat_next_s;
    logic [OUT_W-1:0]   data_next_s;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a completed phase-3 beat returns to IDLE unless a new triple is accepted.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = EMIT;
                else          state_next_s = IDLE;
            end
            EMIT: begin
                if (beat_s && (phase_r == 2'd3)) state_next_s = accept_s ? EMIT : IDLE;
                else                              state_next_s = EMIT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output/handshake decode, normalization and the next beat's data.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            EMIT:    in_ready_s = (phase_r == 2'd3) && out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s  = in_valid && in_ready_s;
        beat_s    = (state_r == EMIT) && out_ready;
        na_s      = norm_sat(in_a);
        nb_s      = norm_sat(in_b);
        nc_s      = norm_sat(in_c);
        sat_inc_s = {1'b0, na_s[OUT_W]} + {1'b0, nb_s[OUT_W]} + {1'b0, nc_s[OUT_W]};
        sat_sum_s = {1'b0, sat_count_r} + {15'd0, sat_inc_s};
        sat_next_s = sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
        case (phase_r)
            2'd0:    data_next_s = a_r;
            2'd1:    data_next_s = b_r;
            2'd2:    data_next_s = c_r;
            default: data_next_s = out_data_r;
        endcase
    end

    // Holding registers, output beat registers and saturation counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_r     <= 2'd0;
            a_r         <= {OUT_W{1'b0}};
            b_r         <= {OUT_W{1'b0}};
            c_r         <= {OUT_W{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_last_r  <= 1'b0;
            sat_count_r <= 16'd0;
        end else if (accept_s) begin
            phase_r     <= 2'd0;
            a_r         <= na_s[OUT_W-1:0];
            b_r         <= nb_s[OUT_W-1:0];
            c_r         <= nc_s[OUT_W-1:0];
            out_data_r  <= in_center;
            out_last_r  <= 1'b0;
            sat_count_r <= sat_next_s;
        end else if (beat_s) begin
            phase_r     <= phase_r + 2'd1;
            out_data_r  <= data_next_s;
            out_last_r  <= (phase_r == 2'd2);
        end else begin
            phase_r     <= phase_r;
            out_data_r  <= out_data_r;
            out_last_r  <= out_last_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == EMIT);
    assign out_data  = out_data_r;
    assign out_phase = phase_r;
    assign out_last  = out_last_r;
    assign sat_count = sat_count_r;

endmodule

// File: tb/tb_interp_out_serializer.sv
// Directed bench for interp_out_serializer: a rounding instance and a truncating
// instance share stimulus; vectors come from a hand-computed table.
module tb_interp_out_serializer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_center;
    logic [39:0] in_a, in_b, in_c;

    logic        in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [1:0]  out_phase;
    logic [15:0] sat_count;
    logic        t_in_ready, t_out_valid, t_out_last;
    logic [31:0] t_out_data;
    logic [1:0]  t_out_phase;
    logic [15:0] t_sat_count;

    int checks = 0;
    int failures = 0;
    int exp_sat_r = 0;
    int exp_sat_t = 0;

    typedef struct {
        logic [31:0]       cen;
        logic [39:0]       a, b, c;
        logic [2:0][31:0]  er;
        logic [2:0][31:0]  et;
        int                sr;
        int                st;
    } vec_t;

    vec_t vecs[6];

    interp_out_serializer #(.IN_W(40), .OUT_W(32), .NORM_SHIFT(6), .ROUND_EN(1)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_center(in_center), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_phase(out_phase), .out_last(out_last), .sat_count(sat_count)
    );

    interp_out_serializer #(.IN_W(40), .OUT_W(32), .NORM_SHIFT(6), .ROUND_EN(0)) dut_t (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_center(in_center), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .out_phase(t_out_phase), .out_last(t_out_last), .sat_count(t_sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] cen, input logic [39:0] a,
                           input logic [39:0] b, input logic [39:0] c,
                           input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                           input int sr, input int st);
        vecs[i].cen = cen; vecs[i].a = a; vecs[i].b = b; vecs[i].c = c;
        vecs[i].er[0] = r0; vecs[i].er[1] = r1; vecs[i].er[2] = r2;
        vecs[i].et[0] = t0; vecs[i].et[1] = t1; vecs[i].et[2] = t2;
        vecs[i].sr = sr; vecs[i].st = st;
    endtask

    task automatic drive(input int v);
        in_center = vecs[v].cen; in_a = vecs[v].a; in_b = vecs[v].b; in_c = vecs[v].c;
    endtask

    // Called at a negedge in IDLE or phase 3; returns at the negedge after the accept.
    task automatic send(input int v);
        int waited;
        drive(v);
        in_valid = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clock); #1;
            waited++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        exp_sat_r += vecs[v].sr;
        exp_sat_t += vecs[v].st;
    endtask

    function automatic logic [31:0] beat_r(input int v, input int p);
        return (p == 0) ? vecs[v].cen : vecs[v].er[p-1];
    endfunction

    function automatic logic [31:0] beat_t(input int v, input int p);
        return (p == 0) ? vecs[v].cen : vecs[v].et[p-1];
    endfunction

    task automatic check_beat(input int v, input int p);
        chk("valid",   {39'd0, out_valid}, 40'd1);
        chk("phase",   {38'd0, out_phase}, p[39:0]);
        chk("last",    {39'd0, out_last}, (p == 3) ? 40'd1 : 40'd0);
        chk("data_r",  {8'd0, out_data}, {8'd0, beat_r(v, p)});
        chk("data_t",  {8'd0, t_out_data}, {8'd0, beat_t(v, p)});
    endtask

    // Starts at the negedge after accept with out_ready high; four beats then IDLE.
    task automatic collect(input int v);
        for (int p = 0; p < 4; p++) begin
            check_beat(v, p);
            @(negedge clock);
        end
        chk("idle_valid", {39'd0, out_valid}, 40'd0);
        chk("idle_ready", {39'd0, in_ready}, 40'd1);
        chk("sat_r", {24'd0, sat_count}, exp_sat_r[39:0]);
        chk("sat_t", {24'd0, t_sat_count}, exp_sat_t[39:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 32'd100, 40'd320, 40'd640, -40'sd192,
                32'd5, 32'd10, -32'sd3, 32'd5, 32'd10, -32'sd3, 0, 0);
        set_vec(1, 32'd7, 40'd32, 40'd31, -40'sd32,
                32'd1, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd1, 0, 0);
        set_vec(2, -32'sd5, 40'd64, 40'd63, -40'sd1,
                32'd1, 32'd1, 32'd0, 32'd1, 32'd0, -32'sd1, 0, 0);
        set_vec(3, 32'hFFFF_FFFF, 40'h40_0000_0000, 40'hC0_0000_0000, 40'd0,
                32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 2, 2);
        set_vec(4, 32'h0000_0001, 40'h1F_FFFF_FFC0, 40'h1F_FFFF_FFE0, 40'hE0_0000_0000,
                32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0);
        set_vec(5, 32'h1234_5678, 40'hDF_FFFF_FFDF, 40'h7F_FFFF_FFFF, 40'h80_0000_0000,
                32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 3, 3);

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_center = 32'd0; in_a = 40'd0; in_b = 40'd0; in_c = 40'd0;
        #23 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_valid", {39'd0, out_valid}, 40'd0);
        chk("rst_phase", {38'd0, out_phase}, 40'd0);
        chk("rst_last",  {39'd0, out_last}, 40'd0);
        chk("rst_data",  {8'd0, out_data}, 40'd0);
        chk("rst_sat",   {24'd0, sat_count}, 40'd0);
        chk("rst_ready", {39'd0, in_ready}, 40'd1);

        for (int v = 0; v < 6; v++) begin
            send(v);
            collect(v);
        end

        // Saturation counter clamp: start two below the ceiling.
        force dut.sat_count_r = 16'hFFFE;
        #1 release dut.sat_count_r;
        exp_sat_r = 32'hFFFE;
        send(3);
        exp_sat_r = 32'hFFFF;
        collect(3);
        send(5);
        exp_sat_r = 32'hFFFF;
        collect(5);

        // Backpressure on the phase-2 beat with a new triple waiting.
        send(0);
        check_beat(0, 0); @(negedge clock);
        check_beat(0, 1); @(negedge clock);
        check_beat(0, 2);
        out_ready = 1'b0;
        drive(2);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready", {39'd0, in_ready}, 40'd0);
            check_beat(0, 2);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check_beat(0, 3);
        #1 chk("p3_ready", {39'd0, in_ready}, 40'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        exp_sat_r += vecs[2].sr; exp_sat_t += vecs[2].st;
        collect(2);

        // Back-to-back: three triples, twelve beats, in_ready only on phase 3.
        drive(0);
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 12; k++) begin
            check_beat(k / 4, k % 4);
            chk("b2b_ready", {39'd0, in_ready}, ((k % 4) == 3) ? 40'd1 : 40'd0);
            if ((k % 4) == 3) begin
                if (k < 11) drive(k / 4 + 1);
                else        in_valid = 1'b0;
            end
            @(negedge clock);
        end
        chk("b2b_end", {39'd0, out_valid}, 40'd0);

        // Asynchronous reset during the phase-1 beat.
        send(3);
        check_beat(3, 0); @(negedge clock);
        check_beat(3, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", {39'd0, out_valid}, 40'd0);
        chk("arst_sat",   {24'd0, sat_count}, 40'd0);
        chk("arst_phase", {38'd0, out_phase}, 40'd0);
        #3 reset_n = 1'b1;
        exp_sat_r = 0; exp_sat_t = 0;
        @(negedge clock);
        chk("post_ready", {39'd0, in_ready}, 40'd1);
        chk("post_valid", {39'd0, out_valid}, 40'd0);
        chk("post_sat",   {24'd0, sat_count}, 40'd0);
        send(0);
        collect(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
